// File: rtl/snake_body_stream.sv
// Snake segment store: moves the head one cell per step, grows on is_eat, detects walls
// and self hits, and streams the body head-first framed by vld_start / vld / vld_t.
module snake_body_stream #(
   parameter int H_LOGIC_WIDTH = 5,
   parameter int V_LOGIC_WIDTH = 5,
   parameter int H_LOGIC_MAX   = 31,
   parameter int V_LOGIC_MAX   = 23,
   parameter int MAX_LEN       = 64,
   parameter int INIT_LEN      = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step,
   input  logic [1:0]               dir,
   input  logic                     is_eat,
   output logic [H_LOGIC_WIDTH-1:0] x_snake_cur,
   output logic [V_LOGIC_WIDTH-1:0] y_snake_cur,
   output logic [9:0]               length,
   output logic                     vld_start,
   output logic                     vld,
   output logic                     vld_t,
   output logic                     is_end,
   output logic                     busy,
   output logic [1:0]               state_dbg
);
   localparam int IDX_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
   localparam logic [H_LOGIC_WIDTH-1:0] X_MAX = H_LOGIC_WIDTH'(H_LOGIC_MAX);
   localparam logic [V_LOGIC_WIDTH-1:0] Y_MAX = V_LOGIC_WIDTH'(V_LOGIC_MAX);
   localparam logic [H_LOGIC_WIDTH-1:0] X_ONE = H_LOGIC_WIDTH'(1);
   localparam logic [V_LOGIC_WIDTH-1:0] Y_ONE = V_LOGIC_WIDTH'(1);
   localparam logic [9:0]               LEN_MAX = 10'(MAX_LEN);
   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVE   = 2'd1,
      S_STREAM = 2'd2,
      S_DEAD   = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [1:0]                 heading_q, heading_d;
   logic [9:0]                 len_q;
   logic [10:0]                cnt_q;
   logic                       grow_q, hit_q, end_q;
   logic [H_LOGIC_WIDTH-1:0]   last_x_q;
   logic [V_LOGIC_WIDTH-1:0]   last_y_q;
   logic [H_LOGIC_WIDTH-1:0]   seg_x_q [MAX_LEN];
   logic [V_LOGIC_WIDTH-1:0]   seg_y_q [MAX_LEN];

   logic [H_LOGIC_WIDTH-1:0]   head_x;
   logic [V_LOGIC_WIDTH-1:0]   head_y;
   logic                       wall, grow_req, seg_vld, frame_end, self_hit;
   logic [10:0]                len_ext;
   logic [IDX_W-1:0]           rd_idx;

   // A request exactly opposite the current heading is dropped, not reversed into the neck.
   always_comb begin
      heading_d = dir;
      if ((dir[1] == heading_q[1]) && (dir[0] != heading_q[0])) heading_d = heading_q;
      head_x = seg_x_q[0];
      head_y = seg_y_q[0];
      wall   = 1'b0;
      case (heading_d)
         DIR_RIGHT: if (seg_x_q[0] == X_MAX) wall = 1'b1; else head_x = seg_x_q[0] + X_ONE;
         DIR_LEFT:  if (seg_x_q[0] == '0)    wall = 1'b1; else head_x = seg_x_q[0] - X_ONE;
         DIR_UP:    if (seg_y_q[0] == '0)    wall = 1'b1; else head_y = seg_y_q[0] - Y_ONE;
         default:   if (seg_y_q[0] == Y_MAX) wall = 1'b1; else head_y = seg_y_q[0] + Y_ONE;
      endcase
   end

   // Frame counter: 0 = vld_start, 1..len = segment len-1 index+1, len+1 = vld_t.
   assign len_ext   = {1'b0, len_q};
   assign seg_vld   = (state_q == S_STREAM) && (cnt_q != 11'd0) && (cnt_q <= len_ext);
   assign frame_end = (state_q == S_STREAM) && (cnt_q == len_ext + 11'd1);
   assign rd_idx    = IDX_W'(cnt_q - 11'd1);
   assign self_hit  = seg_vld && (cnt_q >= 11'd2) &&
                      (seg_x_q[rd_idx] == seg_x_q[0]) && (seg_y_q[rd_idx] == seg_y_q[0]);
   assign grow_req  = grow_q | is_eat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (step) state_d = S_MOVE;
         S_MOVE:   state_d = wall ? S_DEAD : S_STREAM;
         S_STREAM: if (frame_end) state_d = hit_q ? S_DEAD : S_IDLE;
         default:  state_d = S_DEAD;
      endcase
   end

   always_comb begin
      vld_start   = (state_q == S_STREAM) && (cnt_q == 11'd0);
      vld         = seg_vld;
      vld_t       = frame_end;
      busy        = (state_q != S_IDLE);
      x_snake_cur = seg_vld ? seg_x_q[rd_idx] : last_x_q;
      y_snake_cur = seg_vld ? seg_y_q[rd_idx] : last_y_q;
   end

   assign length    = len_q;
   assign is_end    = end_q;
   assign state_dbg = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         heading_q <= DIR_RIGHT;
         len_q     <= 10'(INIT_LEN);
         cnt_q     <= '0;
         grow_q    <= 1'b0;
         hit_q     <= 1'b0;
         end_q     <= 1'b0;
         last_x_q  <= '0;
         last_y_q  <= '0;
         for (int k = 0; k < MAX_LEN; k++) begin
            seg_x_q[k] <= (k < INIT_LEN) ? H_LOGIC_WIDTH'(INIT_LEN - 1 - k) : '0;
            seg_y_q[k] <= '0;
         end
      end else begin
         if (is_eat && (state_q != S_DEAD)) grow_q <= 1'b1;
         case (state_q)
            S_MOVE: begin
               cnt_q <= '0;
               hit_q <= 1'b0;
               if (wall) begin
                  end_q <= 1'b1;
               end else begin
                  heading_q  <= heading_d;
                  seg_x_q[0] <= head_x;
                  seg_y_q[0] <= head_y;
                  for (int k = 1; k < MAX_LEN; k++) begin
                     seg_x_q[k] <= seg_x_q[k-1];
                     seg_y_q[k] <= seg_y_q[k-1];
                  end
                  if (grow_req) begin
                     if (len_q < LEN_MAX) len_q <= len_q + 10'd1;
                     grow_q <= 1'b0;
                  end
               end
            end
            S_STREAM: begin
               cnt_q <= cnt_q + 11'd1;
               if (self_hit) hit_q <= 1'b1;
               if (seg_vld) begin
                  last_x_q <= x_snake_cur;
                  last_y_q <= y_snake_cur;
               end
               if (frame_end && hit_q) end_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_body_stream.sv
// Bench for snake_body_stream: two instances (MAX_LEN 64 and 4) share one stimulus stream
// and are checked against a head-history model plus directed tables and sequences.
module tb_snake_body_stream;
   localparam int HMAX = 31;
   localparam int VMAX = 23;
   localparam int INIT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       step = 1'b0;
   logic       is_eat = 1'b0;
   logic [1:0] dir = 2'b00;

   logic [4:0] x_w [2];
   logic [4:0] y_w [2];
   logic [9:0] len_w [2];
   logic       vs_w [2];
   logic       v_w [2];
   logic       vt_w [2];
   logic       end_w [2];
   logic       busy_w [2];
   logic [1:0] st_w [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   snake_body_stream #(.MAX_LEN(64)) dut_a (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .is_eat(is_eat),
      .x_snake_cur(x_w[0]), .y_snake_cur(y_w[0]), .length(len_w[0]),
      .vld_start(vs_w[0]), .vld(v_w[0]), .vld_t(vt_w[0]),
      .is_end(end_w[0]), .busy(busy_w[0]), .state_dbg(st_w[0])
   );

   snake_body_stream #(.MAX_LEN(4)) dut_b (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .is_eat(is_eat),
      .x_snake_cur(x_w[1]), .y_snake_cur(y_w[1]), .length(len_w[1]),
      .vld_start(vs_w[1]), .vld(v_w[1]), .vld_t(vt_w[1]),
      .is_end(end_w[1]), .busy(busy_w[1]), .state_dbg(st_w[1])
   );

   // Model: the body is the last mlen head positions the snake has occupied.
   int hist_x [2][0:1023];
   int hist_y [2][0:1023];
   int hn [2];
   int mlen [2];
   int mmax [2];
   int mdx [2];
   int mdy [2];
   bit mgrow [2];
   bit mdead [2];

   // Frame capture
   int         start_c [2];
   int         t_c [2];
   int         fv_c [2];
   int         nv [2];
   logic [9:0] got_xy [2][0:1023];
   bit         exp_s [2];

   typedef struct {
      logic [1:0] d;
      bit         eat_b;
      bit         eat_w;
      int         exp_len;
      int         exp_hx;
      int         exp_hy;
      bit         exp_s;
      bit         exp_end;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic void model_reset();
      mmax[0] = 64;
      mmax[1] = 4;
      for (int k = 0; k < 2; k++) begin
         hn[k] = INIT;
         for (int i = 0; i < INIT; i++) begin
            hist_x[k][i] = i;
            hist_y[k][i] = 0;
         end
         mlen[k]  = INIT;
         mdx[k]   = 1;
         mdy[k]   = 0;
         mgrow[k] = 1'b0;
         mdead[k] = 1'b0;
      end
   endfunction

   function automatic void model_eat(input int k);
      if (!mdead[k]) mgrow[k] = 1'b1;
   endfunction

   function automatic int body_x(input int k, input int i);
      return hist_x[k][hn[k]-1-i];
   endfunction

   function automatic int body_y(input int k, input int i);
      return hist_y[k][hn[k]-1-i];
   endfunction

   function automatic void model_move(input int k, input logic [1:0] d, input bit eat,
                                      output bit streams);
      int dx, dy, hx, hy;
      streams = 1'b0;
      if (mdead[k]) return;
      case (d)
         2'b00:   begin dx = 1;  dy = 0;  end
         2'b01:   begin dx = -1; dy = 0;  end
         2'b10:   begin dx = 0;  dy = -1; end
         default: begin dx = 0;  dy = 1;  end
      endcase
      if ((dx == -mdx[k]) && (dy == -mdy[k])) begin
         dx = mdx[k];
         dy = mdy[k];
      end
      hx = body_x(k, 0) + dx;
      hy = body_y(k, 0) + dy;
      if ((hx < 0) || (hx > HMAX) || (hy < 0) || (hy > VMAX)) begin
         mdead[k] = 1'b1;
         return;
      end
      mdx[k] = dx;
      mdy[k] = dy;
      hist_x[k][hn[k]] = hx;
      hist_y[k][hn[k]] = hy;
      hn[k]++;
      if (mgrow[k] || eat) begin
         if (mlen[k] < mmax[k]) mlen[k]++;
         mgrow[k] = 1'b0;
      end
      streams = 1'b1;
      for (int i = 1; i < mlen[k]; i++)
         if ((body_x(k, i) == hx) && (body_y(k, i) == hy)) mdead[k] = 1'b1;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      step = 1'b0;
      is_eat = 1'b0;
      dir = 2'b00;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_len_%0d", k), int'(len_w[k]), INIT);
         check($sformatf("rst_busy_%0d", k), int'(busy_w[k]), 0);
         check($sformatf("rst_vld_%0d", k), int'(v_w[k]), 0);
         check($sformatf("rst_vs_%0d", k), int'(vs_w[k]), 0);
         check($sformatf("rst_vt_%0d", k), int'(vt_w[k]), 0);
         check($sformatf("rst_end_%0d", k), int'(end_w[k]), 0);
         check($sformatf("rst_xy_%0d", k), int'({x_w[k], y_w[k]}), 0);
         check($sformatf("rst_state_%0d", k), int'(st_w[k]), 0);
      end
      rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic run_step(input logic [1:0] d, input bit eat_b, input bit eat_w, input bit eat_m);
      int         cyc;
      bit         done;
      logic [9:0] exp_q[$];
      if (eat_b) begin
         is_eat = 1'b1;
         @(negedge clk);
         is_eat = 1'b0;
         for (int k = 0; k < 2; k++) model_eat(k);
      end
      for (int k = 0; k < 2; k++) begin
         model_move(k, d, eat_w, exp_s[k]);
         start_c[k] = -1;
         t_c[k]     = -1;
         fv_c[k]    = -1;
         nv[k]      = 0;
      end
      step = 1'b1;
      dir = d;
      is_eat = eat_w;
      @(negedge clk);
      step = 1'b0;
      is_eat = 1'b0;
      cyc = 1;
      done = 1'b0;
      while (!done && (cyc < 2000)) begin
         for (int k = 0; k < 2; k++) begin
            if (vs_w[k] && (start_c[k] < 0)) start_c[k] = cyc;
            if (v_w[k]) begin
               if (fv_c[k] < 0) fv_c[k] = cyc;
               if (nv[k] < 1024) got_xy[k][nv[k]] = {x_w[k], y_w[k]};
               nv[k]++;
            end
            if (vt_w[k] && (t_c[k] < 0)) t_c[k] = cyc;
         end
         if ((cyc == 2) && eat_m) begin
            is_eat = 1'b1;
            for (int k = 0; k < 2; k++) model_eat(k);
         end
         done = (cyc >= 6) && (!busy_w[0] || end_w[0]) && (!busy_w[1] || end_w[1]);
         if (!done) begin
            @(negedge clk);
            is_eat = 1'b0;
            cyc++;
         end
      end
      is_eat = 1'b0;
      check("frame_timeout", int'(done), 1);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("stream_%0d", k), int'(start_c[k] >= 0), int'(exp_s[k]));
         check($sformatf("len_%0d", k), int'(len_w[k]), mlen[k]);
         check($sformatf("end_%0d", k), int'(end_w[k]), int'(mdead[k]));
         if (exp_s[k]) begin
            check($sformatf("vs_cyc_%0d", k), start_c[k], 2);
            check($sformatf("vld_first_%0d", k), fv_c[k], 3);
            check($sformatf("vld_count_%0d", k), nv[k], mlen[k]);
            check($sformatf("vt_cyc_%0d", k), t_c[k], 3 + mlen[k]);
            exp_q.delete();
            for (int i = 0; i < mlen[k]; i++)
               exp_q.push_back({5'(body_x(k, i)), 5'(body_y(k, i))});
            for (int i = 0; (i < mlen[k]) && (i < nv[k]); i++)
               check($sformatf("seg%0d_%0d", i, k), int'(got_xy[k][i]), int'(exp_q.pop_front()));
            check($sformatf("hold_x_%0d", k), int'(x_w[k]), body_x(k, mlen[k]-1));
         end else begin
            check($sformatf("no_vld_%0d", k), nv[k], 0);
         end
      end
   endtask

   initial begin
      tbl[0] = '{2'b00, 1'b0, 1'b0, 3, 3, 0, 1'b1, 1'b0};
      tbl[1] = '{2'b00, 1'b1, 1'b0, 4, 4, 0, 1'b1, 1'b0};
      tbl[2] = '{2'b01, 1'b0, 1'b0, 4, 5, 0, 1'b1, 1'b0};
      tbl[3] = '{2'b11, 1'b0, 1'b1, 5, 5, 1, 1'b1, 1'b0};
      tbl[4] = '{2'b10, 1'b0, 1'b0, 5, 5, 2, 1'b1, 1'b0};
      tbl[5] = '{2'b00, 1'b0, 1'b0, 5, 6, 2, 1'b1, 1'b0};

      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_step(tbl[i].d, tbl[i].eat_b, tbl[i].eat_w, 1'b0);
         check($sformatf("tbl%0d_len", i), int'(len_w[0]), tbl[i].exp_len);
         check($sformatf("tbl%0d_stream", i), int'(start_c[0] >= 0), int'(tbl[i].exp_s));
         check($sformatf("tbl%0d_end", i), int'(end_w[0]), int'(tbl[i].exp_end));
         check($sformatf("tbl%0d_head_x", i), int'(got_xy[0][0][9:5]), tbl[i].exp_hx);
         check($sformatf("tbl%0d_head_y", i), int'(got_xy[0][0][4:0]), tbl[i].exp_hy);
      end

      // Right wall
      while (body_x(0, 0) < HMAX) run_step(2'b00, 1'b0, 1'b0, 1'b0);
      run_step(2'b00, 1'b0, 1'b0, 1'b0);
      check("wall_end", int'(end_w[0]), 1);
      check("wall_no_start", start_c[0], -1);
      run_step(2'b11, 1'b1, 1'b0, 1'b0);
      check("dead_len", int'(len_w[0]), 5);
      check("dead_no_vld", nv[0], 0);
      check("dead_busy", int'(busy_w[0]), 1);

      // Self collision on the long snake; the 4-deep one survives the same path
      do_reset();
      run_step(2'b00, 1'b1, 1'b0, 1'b0);
      run_step(2'b00, 1'b1, 1'b0, 1'b0);
      run_step(2'b11, 1'b0, 1'b0, 1'b0);
      run_step(2'b01, 1'b0, 1'b0, 1'b0);
      run_step(2'b10, 1'b0, 1'b0, 1'b0);
      check("self_hit_end", int'(end_w[0]), 1);
      check("self_hit_vt", t_c[0], 8);
      check("short_alive", int'(end_w[1]), 0);
      run_step(2'b00, 1'b0, 1'b1, 1'b0);
      check("sat_len", int'(len_w[1]), 4);
      check("sat_stream", nv[1], 4);

      // Reset in the middle of a frame
      do_reset();
      step = 1'b1;
      dir = 2'b00;
      @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      check("vld_pre_rst", int'(v_w[0]), 1);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("mid_rst_vld_%0d", k), int'(v_w[k]), 0);
         check($sformatf("mid_rst_vs_%0d", k), int'(vs_w[k]), 0);
         check($sformatf("mid_rst_vt_%0d", k), int'(vt_w[k]), 0);
         check($sformatf("mid_rst_len_%0d", k), int'(len_w[k]), INIT);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      run_step(2'b00, 1'b0, 1'b0, 1'b0);

      // Random play against the model
      for (int i = 0; i < 80; i++) begin
         if (mdead[0] && mdead[1]) do_reset();
         run_step(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
